// File: rtl/trace_capture.sv
// Retirement-trace monitor: packs CPU writeback/memory events into a circular
// buffer drained over valid/ready, with cycle/instruction counters and a watchdog.
module trace_capture #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned WRAP    = 0,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              reg_we,
  input  logic [REG_W-1:0]  reg_dst,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              hlt,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [3:0]        rd_flags,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [REG_W-1:0]  rd_reg,
  output logic [DATA_W-1:0] rd_reg_data,
  output logic [ADDR_W-1:0] rd_mem_addr,
  output logic [DATA_W-1:0] rd_mem_data,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  inst_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              overflow,
  output logic              done,
  output logic              timeout
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE, TMO} traceState;

  traceState state, stateNext;

  logic [PTR_W-1:0] wrPtr, wrPtrNext, rdPtr, rdPtrNext;
  logic [OCC_W-1:0] count, countNext;
  logic [CNT_W-1:0] cycleNext, instNext, dropNext;
  logic             overflowNext;

  logic              active, push, pop, full, notEmpty, doWrite;
  logic [3:0]        evFlags;
  logic [DATA_W-1:0] evMemData;

  logic [3:0]        memFlags   [DEPTH];
  logic [ADDR_W-1:0] memPc      [DEPTH];
  logic [REG_W-1:0]  memReg     [DEPTH];
  logic [DATA_W-1:0] memRegData [DEPTH];
  logic [ADDR_W-1:0] memAddr    [DEPTH];
  logic [DATA_W-1:0] memData    [DEPTH];

  logic [3:0]        headFlags;
  logic [ADDR_W-1:0] headPc;
  logic [REG_W-1:0]  headReg;
  logic [DATA_W-1:0] headRegData;
  logic [ADDR_W-1:0] headMemAddr;
  logic [DATA_W-1:0] headMemData;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Event decode
  always_comb begin
    active    = (state == RUN) && en;
    evFlags   = {hlt, mem_re, mem_we, reg_we};
    evMemData = mem_re ? mem_rdata : mem_wdata;
    push      = active && (evFlags != 4'b0000);
    notEmpty  = (count != '0);
    pop       = notEmpty && rd_ready;
    full      = (count == OCC_W'(DEPTH));
  end

  // Next-state, pointer, occupancy and counter logic
  always_comb begin
    stateNext    = state;
    wrPtrNext    = wrPtr;
    rdPtrNext    = rdPtr;
    countNext    = count;
    cycleNext    = cycle_cnt;
    instNext     = inst_cnt;
    dropNext     = drop_cnt;
    overflowNext = overflow;
    doWrite      = 1'b0;

    if (active) begin
      cycleNext = satInc(cycle_cnt);
      if (hlt || reg_we || mem_we) begin
        instNext = satInc(inst_cnt);
      end
    end

    if (push) begin
      if (pop) begin
        doWrite   = 1'b1;
        wrPtrNext = wrPtr + PTR_W'(1);
        rdPtrNext = rdPtr + PTR_W'(1);
      end else if (!full) begin
        doWrite   = 1'b1;
        wrPtrNext = wrPtr + PTR_W'(1);
        countNext = count + OCC_W'(1);
      end else begin
        dropNext     = satInc(drop_cnt);
        overflowNext = 1'b1;
        // Overwrite mode: write lands on the oldest slot and the head moves past it
        if (WRAP != 0) begin
          doWrite   = 1'b1;
          wrPtrNext = wrPtr + PTR_W'(1);
          rdPtrNext = rdPtr + PTR_W'(1);
        end
      end
    end else if (pop) begin
      rdPtrNext = rdPtr + PTR_W'(1);
      countNext = count - OCC_W'(1);
    end

    case (state)
      RUN: begin
        if (active && hlt) begin
          stateNext = DRAIN;
        end else if (active && (cycleNext >= CNT_W'(TIMEOUT))) begin
          stateNext = TMO;
        end
      end
      DRAIN: begin
        if (countNext == '0) begin
          stateNext = DONE;
        end
      end
      default: stateNext = state;
    endcase
  end

  // Entry presented after this edge; bypass when the new write lands at the head
  always_comb begin
    headFlags   = memFlags[rdPtrNext];
    headPc      = memPc[rdPtrNext];
    headReg     = memReg[rdPtrNext];
    headRegData = memRegData[rdPtrNext];
    headMemAddr = memAddr[rdPtrNext];
    headMemData = memData[rdPtrNext];
    if (doWrite && (wrPtr == rdPtrNext)) begin
      headFlags   = evFlags;
      headPc      = pc;
      headReg     = reg_dst;
      headRegData = reg_data;
      headMemAddr = mem_addr;
      headMemData = evMemData;
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) begin
      memFlags[wrPtr]   <= evFlags;
      memPc[wrPtr]      <= pc;
      memReg[wrPtr]     <= reg_dst;
      memRegData[wrPtr] <= reg_data;
      memAddr[wrPtr]    <= mem_addr;
      memData[wrPtr]    <= evMemData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      cycle_cnt   <= '0;
      inst_cnt    <= '0;
      drop_cnt    <= '0;
      overflow    <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_flags    <= '0;
      rd_pc       <= '0;
      rd_reg      <= '0;
      rd_reg_data <= '0;
      rd_mem_addr <= '0;
      rd_mem_data <= '0;
    end else begin
      wrPtr     <= wrPtrNext;
      rdPtr     <= rdPtrNext;
      count     <= countNext;
      cycle_cnt <= cycleNext;
      inst_cnt  <= instNext;
      drop_cnt  <= dropNext;
      overflow  <= overflowNext;
      done      <= (stateNext == DONE);
      timeout   <= (stateNext == TMO);
      rd_valid  <= (countNext != '0);
      if (countNext != '0) begin
        rd_flags    <= headFlags;
        rd_pc       <= headPc;
        rd_reg      <= headReg;
        rd_reg_data <= headRegData;
        rd_mem_addr <= headMemAddr;
        rd_mem_data <= headMemData;
      end
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: drop (WRAP=0) and overwrite (WRAP=1)
// instances run side by side against a behavioural queue model.
module tb_trace_capture;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TMO_LIM = 20;
  localparam int unsigned CW      = 72;

  typedef struct packed {
    logic [3:0]  flags;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] rgData;
    logic [15:0] memAddr;
    logic [15:0] memData;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, reg_we = 1'b0, mem_re = 1'b0, mem_we = 1'b0, hlt = 1'b0;
  logic        rd_ready = 1'b0;
  logic [15:0] pc = '0, reg_data = '0, mem_addr = '0, mem_wdata = '0, mem_rdata = '0;
  logic [3:0]  reg_dst = '0;

  logic [1:0]  rdValid, ovf, doneO, tmoO;
  logic [3:0]  rdFlags   [2];
  logic [15:0] rdPc      [2];
  logic [3:0]  rdReg     [2];
  logic [15:0] rdRegData [2];
  logic [15:0] rdMemAddr [2];
  logic [15:0] rdMemData [2];
  logic [31:0] cycleCnt  [2];
  logic [31:0] instCnt   [2];
  logic [31:0] dropCnt   [2];

  int errors = 0;
  int checks = 0;

  ent_t        expQ    [2][$];
  int unsigned expCyc  [2];
  int unsigned expInst [2];
  int unsigned expDrop [2];
  logic        expOvf  [2];
  int          expSt   [2];   // 0 RUN, 1 DRAIN, 2 DONE, 3 TMO

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gDut
    trace_capture #(.DEPTH(DEPTH), .WRAP(g), .TIMEOUT(TMO_LIM)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pc(pc), .reg_we(reg_we),
      .reg_dst(reg_dst), .reg_data(reg_data), .mem_re(mem_re), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
      .rd_valid(rdValid[g]), .rd_ready(rd_ready), .rd_flags(rdFlags[g]),
      .rd_pc(rdPc[g]), .rd_reg(rdReg[g]), .rd_reg_data(rdRegData[g]),
      .rd_mem_addr(rdMemAddr[g]), .rd_mem_data(rdMemData[g]),
      .cycle_cnt(cycleCnt[g]), .inst_cnt(instCnt[g]), .drop_cnt(dropCnt[g]),
      .overflow(ovf[g]), .done(doneO[g]), .timeout(tmoO[g])
    );
  end

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic [3:0] f, input logic [15:0] p, input logic [3:0] r,
                              input logic [15:0] rd, input logic [15:0] ma, input logic [15:0] md);
    ent_t e;
    e.flags = f; e.pc = p; e.rg = r; e.rgData = rd; e.memAddr = ma; e.memData = md;
    return e;
  endfunction

  function automatic ent_t idle();
    return mk(4'b0000, 16'h0000, 4'h0, 16'h0000, 16'h0000, 16'h0000);
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < 2; i++) begin
      expQ[i].delete();
      expCyc[i] = 0; expInst[i] = 0; expDrop[i] = 0; expOvf[i] = 1'b0; expSt[i] = 0;
    end
  endfunction

  // Behaviour of one edge for instance i given the inputs just driven
  function automatic void modelEdge(input int i, input ent_t ev, input logic e, input logic rdy);
    logic act, psh, pp;
    act = (expSt[i] == 0) && e;
    psh = act && (ev.flags != 4'b0000);
    pp  = (expQ[i].size() != 0) && rdy;
    if (pp) void'(expQ[i].pop_front());
    if (psh) begin
      if (expQ[i].size() == DEPTH) begin
        expDrop[i]++;
        expOvf[i] = 1'b1;
        if (i == 1) begin
          void'(expQ[i].pop_front());
          expQ[i].push_back(ev);
        end
      end else begin
        expQ[i].push_back(ev);
      end
    end
    if (act) begin
      expCyc[i]++;
      if (ev.flags[3] || ev.flags[1] || ev.flags[0]) expInst[i]++;
    end
    if (expSt[i] == 0) begin
      if (act && ev.flags[3]) expSt[i] = 1;
      else if (act && expCyc[i] >= TMO_LIM) expSt[i] = 3;
    end else if (expSt[i] == 1) begin
      if (expQ[i].size() == 0) expSt[i] = 2;
    end
  endfunction

  task automatic compareAll();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d rd_valid", i), CW'(rdValid[i]), CW'(expQ[i].size() != 0));
      if (expQ[i].size() != 0)
        chk($sformatf("d%0d head", i),
            {rdFlags[i], rdPc[i], rdReg[i], rdRegData[i], rdMemAddr[i], rdMemData[i]}, expQ[i][0]);
      chk($sformatf("d%0d cycle_cnt", i), CW'(cycleCnt[i]), CW'(expCyc[i]));
      chk($sformatf("d%0d inst_cnt", i), CW'(instCnt[i]), CW'(expInst[i]));
      chk($sformatf("d%0d drop_cnt", i), CW'(dropCnt[i]), CW'(expDrop[i]));
      chk($sformatf("d%0d overflow", i), CW'(ovf[i]), CW'(expOvf[i]));
      chk($sformatf("d%0d done", i), CW'(doneO[i]), CW'(expSt[i] == 2));
      chk($sformatf("d%0d timeout", i), CW'(tmoO[i]), CW'(expSt[i] == 3));
    end
  endtask

  // One cycle: check outputs at the falling edge, then drive and update the model
  task automatic step(input ent_t ev, input logic e, input logic rdy);
    @(negedge clk);
    compareAll();
    en = e;
    rd_ready = rdy;
    {hlt, mem_re, mem_we, reg_we} = ev.flags;
    pc = ev.pc; reg_dst = ev.rg; reg_data = ev.rgData; mem_addr = ev.memAddr;
    mem_rdata = ev.flags[2] ? ev.memData : ~ev.memData;
    mem_wdata = ev.flags[2] ? ~ev.memData : ev.memData;
    for (int i = 0; i < 2; i++) modelEdge(i, ev, e, rdy);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst d%0d rd_valid", i), CW'(rdValid[i]), CW'(0));
      chk($sformatf("rst d%0d rd_data", i),
          {rdFlags[i], rdPc[i], rdReg[i], rdRegData[i], rdMemAddr[i], rdMemData[i]}, CW'(0));
      chk($sformatf("rst d%0d counters", i), CW'({cycleCnt[i], instCnt[i]}), CW'(0));
      chk($sformatf("rst d%0d drop_cnt", i), CW'(dropCnt[i]), CW'(0));
      chk($sformatf("rst d%0d flags", i), CW'({ovf[i], doneO[i], tmoO[i]}), CW'(0));
    end
    modelClear();
    en = 1'b0; rd_ready = 1'b0;
    {hlt, mem_re, mem_we, reg_we} = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    modelClear();
    doReset();

    // Basic retire
    step(mk(4'b0001, 16'h0002, 4'd3, 16'h00AB, 16'h0000, 16'h0000), 1'b1, 1'b0);
    repeat (3) step(idle(), 1'b0, 1'b1);
    chk("basic inst_cnt", CW'(instCnt[0]), CW'(1));

    // Load then store
    doReset();
    step(mk(4'b0101, 16'h0004, 4'd1, 16'h1234, 16'h0010, 16'h1234), 1'b1, 1'b0);
    step(mk(4'b0010, 16'h0006, 4'd0, 16'h0000, 16'h0012, 16'h5678), 1'b1, 1'b0);
    step(mk(4'b0100, 16'h0008, 4'd2, 16'h0000, 16'h0014, 16'h9ABC), 1'b1, 1'b0);
    repeat (5) step(idle(), 1'b0, 1'b1);
    chk("ldst inst_cnt", CW'(instCnt[0]), CW'(2));

    // Overflow: six writes into a four-entry buffer with no consumer
    doReset();
    for (int k = 1; k <= 6; k++)
      step(mk(4'b0001, 16'(2 * k), 4'(k), 16'(16'h0100 + k), 16'h0000, 16'h0000), 1'b1, 1'b0);
    step(idle(), 1'b0, 1'b0);
    chk("ovf d0 drop_cnt", CW'(dropCnt[0]), CW'(2));
    chk("ovf d1 drop_cnt", CW'(dropCnt[1]), CW'(2));
    chk("ovf d0 overflow", CW'(ovf[0]), CW'(1));
    repeat (6) step(idle(), 1'b0, 1'b1);

    // Full buffer with simultaneous push and pop
    doReset();
    for (int k = 1; k <= 4; k++)
      step(mk(4'b0010, 16'(16'h0040 + k), 4'h0, 16'h0000, 16'(16'h0200 + k), 16'(16'hC000 + k)), 1'b1, 1'b0);
    step(mk(4'b0010, 16'h0045, 4'h0, 16'h0000, 16'h0205, 16'hC005), 1'b1, 1'b1);
    step(idle(), 1'b0, 1'b0);
    chk("fullpp d0 drop_cnt", CW'(dropCnt[0]), CW'(0));
    repeat (6) step(idle(), 1'b0, 1'b1);

    // Halt then drain; events after halt are ignored
    doReset();
    step(mk(4'b0001, 16'h0010, 4'd5, 16'h0055, 16'h0000, 16'h0000), 1'b1, 1'b0);
    step(mk(4'b0010, 16'h0012, 4'd0, 16'h0000, 16'h0030, 16'h0077), 1'b1, 1'b0);
    step(mk(4'b0100, 16'h0014, 4'd0, 16'h0000, 16'h0032, 16'h0099), 1'b1, 1'b0);
    step(mk(4'b1000, 16'h0016, 4'd0, 16'h0000, 16'h0000, 16'h0000), 1'b1, 1'b0);
    step(mk(4'b0001, 16'h0018, 4'd6, 16'h0066, 16'h0000, 16'h0000), 1'b1, 1'b0);
    step(mk(4'b0010, 16'h001A, 4'd0, 16'h0000, 16'h0034, 16'h0011), 1'b1, 1'b1);
    repeat (5) step(idle(), 1'b0, 1'b1);
    chk("halt d0 done", CW'(doneO[0]), CW'(1));
    chk("halt d0 inst_cnt", CW'(instCnt[0]), CW'(3));

    // Watchdog with a pause, then drain in TMO and reset mid-run
    doReset();
    for (int c = 0; c < TMO_LIM; c++) begin
      if (c == 5) begin
        step(mk(4'b0001, 16'h0F00, 4'd9, 16'hDEAD, 16'h0000, 16'h0000), 1'b0, 1'b0);
        step(idle(), 1'b0, 1'b0);
      end
      if (c % 4 == 0)
        step(mk(4'b0001, 16'(16'h0100 + c), 4'(c), 16'(16'h0A00 + c), 16'h0000, 16'h0000), 1'b1, 1'b0);
      else
        step(idle(), 1'b1, 1'b0);
    end
    repeat (3) step(mk(4'b0011, 16'h0FFE, 4'd1, 16'h0001, 16'h0002, 16'h0003), 1'b1, 1'b0);
    chk("wdog d0 cycle_cnt", CW'(cycleCnt[0]), CW'(20));
    chk("wdog d0 timeout", CW'(tmoO[0]), CW'(1));
    repeat (2) step(idle(), 1'b0, 1'b1);
    doReset();
    step(idle(), 1'b0, 1'b0);
    step(idle(), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
